// File: rtl/serial_bus_master_ctrl_pkg.sv
// Shared constants for the serial bus master subsystem: widths, FSM
// encodings, decoder target codes and mux select encodings.
package serial_bus_master_ctrl_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int DEC_BITS = 4;
    localparam int CNT_W    = $clog2(ADDR_W);
    localparam int DIDX_W   = $clog2(DATA_W);
    localparam int BCNT_W   = $clog2(DEC_BITS + 1);
    localparam int NUM_REQ  = 3;

    // Arbiter request/grant slots, lowest index has highest priority
    localparam int ARB_SPLIT = 0;
    localparam int ARB_PORT  = 1;
    localparam int ARB_I2    = 2;

    // Initiator port FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_SPLIT = 3'd6;

    // Leading address bits that select each target
    localparam logic [DEC_BITS-1:0] DEC_T1 = 4'b0000;
    localparam logic [DEC_BITS-1:0] DEC_T2 = 4'b0100;
    localparam logic [DEC_BITS-1:0] DEC_T3 = 4'b1000;

    localparam logic [1:0] SEL_T1 = 2'b00;
    localparam logic [1:0] SEL_T2 = 2'b01;
    localparam logic [1:0] SEL_T3 = 2'b10;

    // Latched transaction fields
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
    } txn_t;

    // States in which the port keeps its arbiter request asserted
    function automatic logic holds_req(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_REQ) || (st == ST_ADDR) ||
               (st == ST_DATA) || (st == ST_READ);
    endfunction

endpackage

// File: rtl/addr_decoder_core.sv
// Snoops the serial address phase and selects one of three targets from
// the leading address bits.
module addr_decoder_core
    import serial_bus_master_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       bus_mode,
    input  logic       grant,
    input  logic       dec_split,
    output logic       target_1_valid,
    output logic       target_2_valid,
    output logic       target_3_valid,
    output logic [1:0] sel
);

    logic [BCNT_W-1:0]   bcnt;
    logic [DEC_BITS-2:0] sh;
    logic [DEC_BITS-1:0] code;
    logic                addr_bit;

    assign addr_bit = bit_valid && !bus_mode;
    assign code     = {sh, bit_in};

    // Count address bits, shift in the leading ones, decode on the last
    // leading bit, and release the selection when the bus is given up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt           <= '0;
            sh             <= '0;
            target_1_valid <= 1'b0;
            target_2_valid <= 1'b0;
            target_3_valid <= 1'b0;
            sel            <= SEL_T1;
        end else begin
            if (addr_bit) begin
                sh <= {sh[DEC_BITS-3:0], bit_in};
                if (bcnt < BCNT_W'(DEC_BITS)) bcnt <= bcnt + BCNT_W'(1);
            end else begin
                bcnt <= '0;
            end

            if (addr_bit && bcnt == BCNT_W'(DEC_BITS - 1)) begin
                target_1_valid <= (code == DEC_T1);
                target_2_valid <= (code == DEC_T2);
                target_3_valid <= (code == DEC_T3);
                case (code)
                    DEC_T2:  sel <= SEL_T2;
                    DEC_T3:  sel <= SEL_T3;
                    default: sel <= SEL_T1;
                endcase
            end else if (!grant && !dec_split) begin
                target_1_valid <= 1'b0;
                target_2_valid <= 1'b0;
                target_3_valid <= 1'b0;
                sel            <= SEL_T1;
            end
        end
    end

endmodule

// File: rtl/arbiter_core.sv
// Fixed-priority, non-preemptive bus arbiter with registered one-hot grant.
module arbiter_core
    import serial_bus_master_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] grant_nxt;

    // Keep the current holder while it requests; otherwise pick the
    // highest-priority requester (lowest index wins)
    always_comb begin
        grant_nxt = grant;
        if ((grant & req) == '0) begin
            grant_nxt = '0;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_nxt    = '0;
                    grant_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Grant register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) grant <= '0;
        else     grant <= grant_nxt;
    end

endmodule

// File: rtl/init_port_core.sv
// Initiator port: latches one transaction, requests the bus, serialises
// address/data MSB-first and assembles serial read data.
module init_port_core
    import serial_bus_master_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] init_addr_out,
    input  logic              init_addr_out_valid,
    input  logic [DATA_W-1:0] init_data_out,
    input  logic              init_data_out_valid,
    input  logic              init_rw,
    input  logic              init_ready,
    input  logic              target_split,
    input  logic              target_ack,
    input  logic              bus_data_in,
    input  logic              bus_data_in_valid,
    input  logic              port_grant,
    output logic              port_req,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    output logic              bus_init_rw,
    output logic              bus_init_ready,
    output logic [DATA_W-1:0] init_data_in,
    output logic              init_data_in_valid,
    output logic              init_ack,
    output logic              init_split_ack
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    txn_t              txn;
    logic [DATA_W-1:0] rd_sh;
    logic [CNT_W-1:0]  a_idx;
    logic [DIDX_W-1:0] d_idx;

    assign a_idx       = CNT_W'(ADDR_W - 1) - cnt;
    assign d_idx       = DIDX_W'(DATA_W - 1) - cnt[DIDX_W-1:0];
    assign port_req    = init_req && holds_req(state);
    assign bus_init_rw = txn.rw;

    // Serial output decode from state and bit counter
    always_comb begin
        bus_data_out_valid = (state == ST_ADDR) || (state == ST_DATA);
        bus_mode           = (state == ST_DATA) || (state == ST_READ);
        bus_data_out       = 1'b0;
        if (state == ST_ADDR)      bus_data_out = txn.addr[a_idx];
        else if (state == ST_DATA) bus_data_out = txn.data[d_idx];
    end

    // Transaction FSM; grant loss beats split, split beats progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            txn                <= '0;
            rd_sh              <= '0;
            init_data_in       <= '0;
            init_data_in_valid <= 1'b0;
            init_split_ack     <= 1'b0;
            init_ack           <= 1'b0;
            bus_init_ready     <= 1'b0;
        end else begin
            init_ack           <= target_ack;
            bus_init_ready     <= init_ready;
            init_data_in_valid <= 1'b0;
            init_split_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (init_addr_out_valid) begin
                        txn.addr <= init_addr_out;
                        txn.rw   <= init_rw;
                    end
                    if (init_data_out_valid) txn.data <= init_data_out;
                    if (init_req) state <= ST_REQ;
                end
                ST_REQ: begin
                    cnt <= '0;
                    if (!init_req)       state <= ST_IDLE;
                    else if (port_grant) state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (!port_grant) state <= ST_IDLE;
                    else if (target_split) begin
                        state          <= ST_SPLIT;
                        init_split_ack <= 1'b1;
                    end else if (cnt == CNT_W'(ADDR_W - 1)) begin
                        cnt   <= '0;
                        state <= txn.rw ? ST_DATA : ST_READ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (!port_grant) state <= ST_IDLE;
                    else if (target_split) begin
                        state          <= ST_SPLIT;
                        init_split_ack <= 1'b1;
                    end else if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (!port_grant) state <= ST_IDLE;
                    else if (target_split) begin
                        state          <= ST_SPLIT;
                        init_split_ack <= 1'b1;
                    end else if (bus_data_in_valid) begin
                        rd_sh <= {rd_sh[DATA_W-2:0], bus_data_in};
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            init_data_in       <= {rd_sh[DATA_W-2:0], bus_data_in};
                            init_data_in_valid <= 1'b1;
                            cnt                <= '0;
                            state              <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!init_req) state <= ST_IDLE;
                end
                ST_SPLIT: begin
                    // Wait for the bus to be released, then re-request and
                    // restart from the first address bit
                    cnt <= '0;
                    if (!port_grant) state <= ST_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_bus_master_ctrl.sv
// Top: initiator port, 3-way arbiter and address decoder wired together.
module serial_bus_master_ctrl
    import serial_bus_master_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] init_addr_out,
    input  logic              init_addr_out_valid,
    input  logic [DATA_W-1:0] init_data_out,
    input  logic              init_data_out_valid,
    input  logic              init_rw,
    input  logic              init_ready,
    input  logic              target_split,
    input  logic              target_ack,
    input  logic              bus_data_in,
    input  logic              bus_data_in_valid,
    input  logic              req_i_2,
    input  logic              req_split,
    input  logic              dec_split,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    output logic              bus_init_rw,
    output logic              bus_init_ready,
    output logic              init_grant,
    output logic [DATA_W-1:0] init_data_in,
    output logic              init_data_in_valid,
    output logic              init_ack,
    output logic              init_split_ack,
    output logic              grant_i_2,
    output logic              grant_split,
    output logic              target_1_valid,
    output logic              target_2_valid,
    output logic              target_3_valid,
    output logic [1:0]        sel
);

    logic               port_req;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;

    always_comb begin
        req            = '0;
        req[ARB_SPLIT] = req_split;
        req[ARB_PORT]  = port_req;
        req[ARB_I2]    = req_i_2;
    end

    assign grant_split = grant[ARB_SPLIT];
    assign init_grant  = grant[ARB_PORT];
    assign grant_i_2   = grant[ARB_I2];

    init_port_core u_port (
        .clk                 (clk),
        .rst                 (rst),
        .init_req            (init_req),
        .init_addr_out       (init_addr_out),
        .init_addr_out_valid (init_addr_out_valid),
        .init_data_out       (init_data_out),
        .init_data_out_valid (init_data_out_valid),
        .init_rw             (init_rw),
        .init_ready          (init_ready),
        .target_split        (target_split),
        .target_ack          (target_ack),
        .bus_data_in         (bus_data_in),
        .bus_data_in_valid   (bus_data_in_valid),
        .port_grant          (grant[ARB_PORT]),
        .port_req            (port_req),
        .bus_data_out        (bus_data_out),
        .bus_data_out_valid  (bus_data_out_valid),
        .bus_mode            (bus_mode),
        .bus_init_rw         (bus_init_rw),
        .bus_init_ready      (bus_init_ready),
        .init_data_in        (init_data_in),
        .init_data_in_valid  (init_data_in_valid),
        .init_ack            (init_ack),
        .init_split_ack      (init_split_ack)
    );

    arbiter_core u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    addr_decoder_core u_dec (
        .clk            (clk),
        .rst            (rst),
        .bit_in         (bus_data_out),
        .bit_valid      (bus_data_out_valid),
        .bus_mode       (bus_mode),
        .grant          (grant[ARB_PORT]),
        .dec_split      (dec_split),
        .target_1_valid (target_1_valid),
        .target_2_valid (target_2_valid),
        .target_3_valid (target_3_valid),
        .sel            (sel)
    );

endmodule

// File: tb/tb_serial_bus_master_ctrl.sv
// Directed bench for serial_bus_master_ctrl: write/read transfers,
// arbitration priority, decode miss, split restart and mid-transfer reset.
module tb_serial_bus_master_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 0, init_addr_out_valid = 0, init_data_out_valid = 0;
    logic [15:0] init_addr_out = '0;
    logic [7:0]  init_data_out = '0;
    logic        init_rw = 0, init_ready = 0, target_split = 0, target_ack = 0;
    logic        bus_data_in = 0, bus_data_in_valid = 0;
    logic        req_i_2 = 0, req_split = 0, dec_split = 0;
    logic        bus_data_out, bus_data_out_valid, bus_mode, bus_init_rw, bus_init_ready;
    logic        init_grant, init_data_in_valid, init_ack, init_split_ack;
    logic        grant_i_2, grant_split, target_1_valid, target_2_valid, target_3_valid;
    logic [7:0]  init_data_in;
    logic [1:0]  sel;

    int checks = 0;
    int errors = 0;

    // Per-transaction observations
    logic [15:0] abits;
    logic [7:0]  dbits, rdata;
    logic [1:0]  lsel;
    logic        saw1, saw2, saw3, rw_seen, tmo;
    int          na, nd, nr, n_div, n_sack, gcyc;
    logic        reached;

    always #5 clk = ~clk;

    serial_bus_master_ctrl dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
        .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
        .init_rw(init_rw), .init_ready(init_ready), .target_split(target_split),
        .target_ack(target_ack), .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid), .req_i_2(req_i_2),
        .req_split(req_split), .dec_split(dec_split),
        .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode), .bus_init_rw(bus_init_rw), .bus_init_ready(bus_init_ready),
        .init_grant(init_grant), .init_data_in(init_data_in),
        .init_data_in_valid(init_data_in_valid), .init_ack(init_ack),
        .init_split_ack(init_split_ack), .grant_i_2(grant_i_2), .grant_split(grant_split),
        .target_1_valid(target_1_valid), .target_2_valid(target_2_valid),
        .target_3_valid(target_3_valid), .sel(sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] all_outs();
        return {bus_data_out, bus_data_out_valid, bus_mode, bus_init_rw, bus_init_ready,
                init_grant, init_data_in, init_data_in_valid, init_ack, init_split_ack,
                grant_i_2, grant_split, target_1_valid, target_2_valid, target_3_valid, sel};
    endfunction

    // Drive one transaction and record what appears on the bus until the
    // port finishes and the bus is released
    task automatic run_txn(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input logic [7:0] rb, input int split_bit);
        int  tail;
        int  cyc;
        logic fin, split_sent;
        init_addr_out = a; init_addr_out_valid = 1; init_data_out = d;
        init_data_out_valid = 1; init_rw = rw; init_req = 1;
        abits = '0; dbits = '0; rdata = '0; lsel = '0; saw1 = 0; saw2 = 0; saw3 = 0;
        rw_seen = 0; na = 0; nd = 0; nr = 0; n_div = 0; n_sack = 0; gcyc = -1;
        tail = -1; cyc = 0; fin = 0; split_sent = 0;
        while (!fin && cyc < 300) begin
            target_split = 0;
            bus_data_in_valid = 0;
            if (cyc > 0) begin
                init_addr_out_valid = 0;
                init_data_out_valid = 0;
            end
            if (init_grant && gcyc < 0) gcyc = cyc;
            if (init_split_ack) begin
                n_sack++;
                na = 0;
                abits = '0;
            end
            if (bus_data_out_valid && !bus_mode) begin
                if (na == 0) rw_seen = bus_init_rw;
                abits = {abits[14:0], bus_data_out};
                na++;
            end
            if (bus_data_out_valid && bus_mode) begin
                dbits = {dbits[6:0], bus_data_out};
                nd++;
            end
            if (init_data_in_valid) begin
                n_div++;
                rdata = init_data_in;
            end
            saw1 |= target_1_valid;
            saw2 |= target_2_valid;
            saw3 |= target_3_valid;
            if (target_1_valid || target_2_valid || target_3_valid) lsel = sel;
            if (split_bit >= 0 && !split_sent && bus_data_out_valid && !bus_mode &&
                na == split_bit + 1) begin
                target_split = 1;
                split_sent = 1;
            end
            if (bus_mode && !bus_data_out_valid && nr < 8) begin
                bus_data_in = rb[3'(7 - nr)];
                bus_data_in_valid = 1;
                nr++;
            end
            if (tail < 0 && ((rw && nd == 8) || (!rw && n_div > 0))) begin
                init_req = 0;
                tail = 4;
            end
            if (tail == 0) fin = 1;
            else begin
                if (tail > 0) tail--;
                step();
                cyc++;
            end
        end
        tmo = !fin;
        init_req = 0;
        target_split = 0;
        bus_data_in_valid = 0;
    endtask

    initial begin
        // Reset state
        step();
        chk("reset_outputs", 32'(all_outs()), 32'h0);
        step();
        rst = 0;
        step();
        chk("idle_outputs", 32'(all_outs()), 32'h0);

        // Registered mirrors and the second initiator's grant
        target_ack = 1; init_ready = 1; req_i_2 = 1;
        step();
        chk("init_ack_mirror", 32'(init_ack), 32'h1);
        chk("bus_init_ready", 32'(bus_init_ready), 32'h1);
        chk("grant_i_2", 32'(grant_i_2), 32'h1);
        target_ack = 0; init_ready = 0; req_i_2 = 0;
        step();
        chk("init_ack_clear", 32'(init_ack), 32'h0);
        chk("grant_i_2_release", 32'(grant_i_2), 32'h0);

        // Write 0x800A / 0x5C -> target 3
        run_txn(16'h800A, 8'h5C, 1'b1, 8'h00, -1);
        chk("wr1_timeout", 32'(tmo), 32'h0);
        chk("wr1_grant_latency", 32'(gcyc), 32'd1);
        chk("wr1_addr_stream", 32'(abits), 32'h800A);
        chk("wr1_addr_len", 32'(na), 32'd16);
        chk("wr1_data_stream", 32'(dbits), 32'h5C);
        chk("wr1_data_len", 32'(nd), 32'd8);
        chk("wr1_rw", 32'(rw_seen), 32'h1);
        chk("wr1_targets_seen", 32'({saw1, saw2, saw3}), 32'b001);
        chk("wr1_sel", 32'(lsel), 32'b10);
        chk("wr1_released", 32'({init_grant, target_1_valid, target_2_valid, target_3_valid}), 32'h0);

        // Read 0x0123, target returns 0xA5 -> target 1
        run_txn(16'h0123, 8'h00, 1'b0, 8'hA5, -1);
        chk("rd_timeout", 32'(tmo), 32'h0);
        chk("rd_addr_stream", 32'(abits), 32'h0123);
        chk("rd_no_write_data", 32'(nd), 32'd0);
        chk("rd_rw", 32'(rw_seen), 32'h0);
        chk("rd_data", 32'(rdata), 32'hA5);
        chk("rd_valid_pulses", 32'(n_div), 32'd1);
        chk("rd_targets_seen", 32'({saw1, saw2, saw3}), 32'b100);
        chk("rd_sel", 32'(lsel), 32'b00);

        // Split-target request wins over the port when both rise together
        req_split = 1; init_req = 1; init_rw = 1;
        init_addr_out = 16'h4ABC; init_addr_out_valid = 1;
        init_data_out = 8'h81; init_data_out_valid = 1;
        step();
        chk("arb_split_first", 32'({grant_split, init_grant}), 32'b10);
        init_addr_out_valid = 0; init_data_out_valid = 0;
        step(); step(); step();
        chk("arb_split_held", 32'({grant_split, init_grant, bus_data_out_valid}), 32'b100);
        req_split = 0;
        step();
        chk("arb_port_after", 32'({grant_split, init_grant}), 32'b01);
        run_txn(16'h4ABC, 8'h81, 1'b1, 8'h00, -1);
        chk("arb_timeout", 32'(tmo), 32'h0);
        chk("arb_addr_stream", 32'(abits), 32'h4ABC);
        chk("arb_data_stream", 32'(dbits), 32'h81);
        chk("arb_targets_seen", 32'({saw1, saw2, saw3}), 32'b010);
        chk("arb_sel", 32'(lsel), 32'b01);

        // Undecoded address: no target, transfer still completes
        run_txn(16'hC000, 8'h3C, 1'b1, 8'h00, -1);
        chk("miss_timeout", 32'(tmo), 32'h0);
        chk("miss_addr_stream", 32'(abits), 32'hC000);
        chk("miss_data_stream", 32'(dbits), 32'h3C);
        chk("miss_no_target", 32'({saw1, saw2, saw3}), 32'b000);

        // Split at address bit 5 -> ack pulse, full restart of the address
        run_txn(16'h4321, 8'h99, 1'b1, 8'h00, 5);
        chk("split_timeout", 32'(tmo), 32'h0);
        chk("split_ack_pulses", 32'(n_sack), 32'd1);
        chk("split_restart_len", 32'(na), 32'd16);
        chk("split_restart_addr", 32'(abits), 32'h4321);
        chk("split_data_stream", 32'(dbits), 32'h99);
        chk("split_sel", 32'(lsel), 32'b01);

        // Reset during data bit 3, then a clean write
        init_addr_out = 16'h1234; init_addr_out_valid = 1;
        init_data_out = 8'hF0; init_data_out_valid = 1; init_rw = 1; init_req = 1;
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            init_addr_out_valid = 0; init_data_out_valid = 0;
            if (bus_mode && bus_data_out_valid) reached = 1;
        end
        step(); step(); step();
        chk("rst_reach_data", 32'({reached, bus_mode, bus_data_out_valid}), 32'b111);
        rst = 1; init_req = 0;
        step();
        chk("rst_mid_outputs", 32'(all_outs()), 32'h0);
        rst = 0;
        step();
        chk("rst_after_outputs", 32'(all_outs()), 32'h0);
        run_txn(16'h0055, 8'hAA, 1'b1, 8'h00, -1);
        chk("post_rst_timeout", 32'(tmo), 32'h0);
        chk("post_rst_addr", 32'(abits), 32'h0055);
        chk("post_rst_data", 32'(dbits), 32'hAA);
        chk("post_rst_targets", 32'({saw1, saw2, saw3, lsel}), 32'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
